// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - 1 s prescaler, cascaded h:m:s counter and time-set FSM with blink
// Define TWELVE_HOUR_EN for 1..12 hours with a PM flag; otherwise 0..HOURS_MAX hours and pm is 0.
module time_set_controller #(
  parameter int CLK_DIV   = 50000000,
  parameter int HOURS_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic       pm,
  output logic [1:0] set_state,
  output logic       blink,
  output logic       sec_tick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_DIV / 2 - 1);

  localparam logic [1:0] ST_RUN         = 2'b00;
  localparam logic [1:0] ST_SET_HOURS   = 2'b01;
  localparam logic [1:0] ST_SET_MINUTES = 2'b10;

`ifdef TWELVE_HOUR_EN
  localparam logic [7:0] RESET_HOURS = 8'd12;
`else
  localparam logic [7:0] RESET_HOURS = 8'd0;
`endif

  logic [PW-1:0] prescaler;
  logic [PW-1:0] half_cnt;
  logic [7:0]    hours_inc;
  logic          pm_inc;
  logic [7:0]    minutes_inc;

  assign sec_tick = (set_state == ST_RUN) && (prescaler == PRESC_LAST);

  // Next hour value shared by the carry chain and the SET_HOURS increment.
  always_comb begin
    hours_inc = hours + 8'd1;
    pm_inc    = 1'b0;
`ifdef TWELVE_HOUR_EN
    if (hours == 8'd12) hours_inc = 8'd1;
    pm_inc = (hours == 8'd11) ? ~pm : pm;
`else
    if (hours == 8'(HOURS_MAX)) hours_inc = 8'd0;
`endif
  end

  assign minutes_inc = (minutes == 8'd59) ? 8'd0 : minutes + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      seconds   <= 8'd0;
      minutes   <= 8'd0;
      hours     <= RESET_HOURS;
      pm        <= 1'b0;
      set_state <= ST_RUN;
      prescaler <= '0;
      half_cnt  <= '0;
      blink     <= 1'b1;
    end else begin
      // Half-second blink timer; only meaningful in set states, overridden below otherwise.
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        blink    <= ~blink;
      end else begin
        half_cnt <= half_cnt + PW'(1);
      end

      case (set_state)
        ST_RUN: begin
          blink     <= 1'b1;
          prescaler <= sec_tick ? '0 : prescaler + PW'(1);
          if (sec_tick) begin
            if (seconds == 8'd59) begin
              seconds <= 8'd0;
              if (minutes == 8'd59) begin
                minutes <= 8'd0;
                hours   <= hours_inc;
                pm      <= pm_inc;
              end else begin
                minutes <= minutes + 8'd1;
              end
            end else begin
              seconds <= seconds + 8'd1;
            end
          end
          if (btn_mode) begin
            set_state <= ST_SET_HOURS;
            prescaler <= '0;
            blink     <= 1'b0;
            half_cnt  <= '0;
          end
        end

        ST_SET_HOURS: begin
          prescaler <= '0;
          if (btn_mode) begin
            set_state <= ST_SET_MINUTES;
            blink     <= 1'b0;
            half_cnt  <= '0;
          end else if (btn_inc) begin
            hours <= hours_inc;
            pm    <= pm_inc;
          end
        end

        ST_SET_MINUTES: begin
          prescaler <= '0;
          if (btn_mode) begin
            set_state <= ST_RUN;
            seconds   <= 8'd0;
            blink     <= 1'b1;
          end else if (btn_inc) begin
            minutes <= minutes_inc;
          end
        end

        default: begin
          set_state <= ST_RUN;
          prescaler <= '0;
          blink     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - directed self-checking bench for time_set_controller (CLK_DIV=4)
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [7:0] hours;
  logic       pm;
  logic [1:0] set_state;
  logic       blink;
  logic       sec_tick;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int base;

  time_set_controller #(.CLK_DIV(4), .HOURS_MAX(23)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .seconds(seconds), .minutes(minutes), .hours(hours), .pm(pm),
    .set_state(set_state), .blink(blink), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sec_tick === 1'b1) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      btn_inc = 1'b1;
      @(negedge clk);
      btn_inc = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_h"}, {24'd0, hours}, h);
    check({tag, "_m"}, {24'd0, minutes}, m);
    check({tag, "_s"}, {24'd0, seconds}, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    cycles(2);
    reset = 1'b0;

`ifdef TWELVE_HOUR_EN
    check("rst12_h", {24'd0, hours}, 12);
    check("rst12_pm", {31'd0, pm}, 0);
    pulse_mode();
    pulse_inc(11);
    check("h11_h", {24'd0, hours}, 11);
    check("h11_pm", {31'd0, pm}, 0);
    pulse_inc(1);
    check("h12pm_h", {24'd0, hours}, 12);
    check("h12pm_pm", {31'd0, pm}, 1);
    pulse_inc(12);
    check("h12am_h", {24'd0, hours}, 12);
    check("h12am_pm", {31'd0, pm}, 0);
`else
    check_time("rst", 0, 0, 0);
    check("rst_state", {30'd0, set_state}, 0);
    check("rst_blink", {31'd0, blink}, 1);
    check("rst_tick", {31'd0, sec_tick}, 0);
    check("rst_pm", {31'd0, pm}, 0);

    base = tick_cnt;
    cycles(240);
    check_time("min1", 0, 1, 0);
    check("ticks60", tick_cnt - base, 60);

    cycles(10);
    check("sec2", {24'd0, seconds}, 2);

    pulse_mode();
    check("seth_state", {30'd0, set_state}, 1);
    check("seth_blink", {31'd0, blink}, 0);
    check_time("seth_frozen", 0, 1, 2);

    pulse_inc(23);
    check("h23", {24'd0, hours}, 23);
    pulse_inc(1);
    check("hwrap", {24'd0, hours}, 0);
    pulse_inc(5);
    check("h5", {24'd0, hours}, 5);

    btn_mode = 1'b1;
    btn_inc = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    check("simul_state", {30'd0, set_state}, 2);
    check("simul_h", {24'd0, hours}, 5);
    check("blink_e0", {31'd0, blink}, 0);
    cycles(1);
    check("blink_e1", {31'd0, blink}, 0);
    check("tick_set1", {31'd0, sec_tick}, 0);
    cycles(1);
    check("blink_e2", {31'd0, blink}, 1);
    cycles(1);
    check("blink_e3", {31'd0, blink}, 1);
    check("tick_set3", {31'd0, sec_tick}, 0);
    cycles(1);
    check("blink_e4", {31'd0, blink}, 0);

    pulse_inc(58);
    check("m59", {24'd0, minutes}, 59);
    pulse_inc(1);
    check_time("mwrap", 5, 0, 2);

    pulse_mode();
    check("run_state", {30'd0, set_state}, 0);
    check("run_blink", {31'd0, blink}, 1);
    check_time("run_exit", 5, 0, 0);
    cycles(2);
    check("first_tick_early", {31'd0, sec_tick}, 0);
    cycles(1);
    check("first_tick", {31'd0, sec_tick}, 1);
    cycles(1);
    check("first_sec", {24'd0, seconds}, 1);

    pulse_mode();
    base = tick_cnt;
    pulse_inc(18);
    pulse_mode();
    pulse_inc(59);
    check_time("set2359", 23, 59, 1);
    check("no_ticks_set", tick_cnt - base, 0);
    pulse_mode();
    check_time("run2359", 23, 59, 0);
    cycles(239);
    check_time("pre_roll", 23, 59, 59);
    check("pre_roll_tick", {31'd0, sec_tick}, 1);
    cycles(1);
    check_time("roll", 0, 0, 0);

    pulse_mode();
    pulse_inc(7);
    pulse_mode();
    pulse_inc(42);
    check_time("t0742", 7, 42, 0);
    check("t0742_state", {30'd0, set_state}, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_time("mid_rst", 0, 0, 0);
    check("mid_rst_state", {30'd0, set_state}, 0);
    check("mid_rst_blink", {31'd0, blink}, 1);
    check("mid_rst_tick", {31'd0, sec_tick}, 0);
    cycles(2);
    check("mid_rst_tick2", {31'd0, sec_tick}, 0);
    cycles(1);
    check("mid_rst_tick3", {31'd0, sec_tick}, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Timekeeping sequencer for the digital clock: divides the system clock into a 1 s tick and runs the cascaded seconds/minutes/hours count.
- Owns the user time-set state machine. Debounced single-cycle button pulses walk RUN -> SET_HOURS -> SET_MINUTES -> RUN, and an increment button adjusts the selected field.
- Drives the display path (seconds/minutes/hours, blink) and replaces the free-running per-unit clock generators with one synchronous clock plus tick enables.

Parameters:
- CLK_DIV, 50000000, clk cycles per second tick; even, >= 2.
- HOURS_MAX, 23, last hour value in 24 h mode; hours wrap HOURS_MAX -> 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_mode  input  1  one-cycle pulse (debounced upstream); advances set state.
- btn_inc  input  1  one-cycle pulse; increments field selected in set states.
- seconds  output  8  binary seconds, 0..59.
- minutes  output  8  binary minutes, 0..59.
- hours  output  8  binary hours, 0..HOURS_MAX (1..12 with TWELVE_HOUR_EN).
- pm  output  1  PM flag; constant 0 without TWELVE_HOUR_EN.
- set_state  output  2  00 RUN, 01 SET_HOURS, 10 SET_MINUTES; 11 unused.
- blink  output  1  display-enable for the field being set.
- sec_tick  output  1  high for one cycle each second, RUN only.

Behaviour:
- Reset (checked on clk edge, overrides all inputs):
  - seconds = minutes = hours = 0.
  - State RUN, prescaler = 0, blink = 1, sec_tick = 0, pm = 0.
  - With TWELVE_HOUR_EN, hours = 12.
- Prescaler: counts 0..CLK_DIV-1 and wraps. Runs only in RUN and is held at 0 in set states.
- sec_tick is combinational: RUN && prescaler == CLK_DIV-1.
- Count update: on the edge ending a sec_tick cycle:
  - seconds+1; 59 -> 0 with carry to minutes.
  - minutes+1; 59 -> 0 with carry to hours.
  - hours+1; HOURS_MAX -> 0.
  - Full carry chain resolves in a single edge, e.g. 23:59:59 -> 00:00:00.
- State machine, driven by btn_mode:
  - RUN -> SET_HOURS; SET_HOURS -> SET_MINUTES; SET_MINUTES -> RUN.
  - On the SET_MINUTES -> RUN edge: seconds cleared to 0 and prescaler restarts at 0, so the first tick comes CLK_DIV cycles later.
- btn_inc:
  - Ignored in RUN.
  - SET_HOURS: hours+1 with wrap; minutes and seconds untouched.
  - SET_MINUTES: minutes+1, 59 -> 0, no carry into hours.
- Simultaneous btn_mode and btn_inc in the same cycle: mode transition taken, inc discarded.
- Time is frozen in set states; no ticks are lost or queued.
- Blink:
  - Held 1 in RUN.
  - In set states, an internal half-second counter toggles blink every CLK_DIV/2 cycles.
  - Entering any set state forces blink = 0 on the entry edge and restarts the half-second count.
- All outputs are registered except sec_tick.
- Output latency: 1 cycle from button pulse to updated field/state.

Optional Feature:
- Macro TWELVE_HOUR_EN.
- Defined:
  - hours range 1..12 plus pm flag; HOURS_MAX ignored.
  - Sequence: 11 AM -> 12 PM -> 1 PM ... 11 PM -> 12 AM (pm toggles on the 11 -> 12 step).
  - The same 24-step cycle applies to btn_inc in SET_HOURS.
  - Reset: 12 AM.
- Undefined: 24 h behaviour as above; pm tied 0.

Test Plan:
- Reset (CLK_DIV=4): assert reset 2 cycles -> 00:00:00, set_state=00, blink=1, sec_tick=0; after 240 cycles -> 00:01:00, and sec_tick pulsed exactly 60 times.
- Rollover: set 23:59 via buttons, return to RUN, wait 60 ticks -> 00:00:00 on the edge of the 60th sec_tick.
- Set wrap: in SET_HOURS give 24 btn_inc pulses -> hours back to 0; in SET_MINUTES give 60 pulses -> minutes 0 with hours unchanged; seconds 0 on exit to RUN.
- Simultaneous btn_mode+btn_inc in SET_HOURS with hours=5 -> set_state=10, hours stays 5; no sec_tick while in set states; blink period = 4 cycles.
- Reset mid-operation: in SET_MINUTES at 07:42 assert reset -> 00:00:00, RUN, blink=1, prescaler restarts (first tick 4 cycles after release).
- TWELVE_HOUR_EN: after reset 12 AM; 12 btn_inc pulses in SET_HOURS -> 12 PM (pm=1); 12 more -> 12 AM (pm=0).
